// File: rtl/clkdiv_pkg.sv
// ---------------------------------------------------------------------------
// clkdiv_pkg
// Shared definitions for the multi-channel clock divider.
//   DEFAULT_HALF_VALUE : half-period a channel loads at reset when the
//                        instantiating level does not override it
//   chan_op_t          : the single action a channel takes on a given edge
//   ch_width()         : width of a channel index, never less than one bit
// ---------------------------------------------------------------------------
package clkdiv_pkg;

   localparam int DEFAULT_HALF_VALUE = 50_000_000;

   typedef enum logic [2:0] {
      OP_COUNT,
      OP_TOGGLE,
      OP_APPLY,
      OP_IDLE,
      OP_SYNC
   } chan_op_t;

   function automatic int ch_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// ---------------------------------------------------------------------------
// clkdiv_channel
// One divider channel: half-period counter, pending-update register and the
// period-boundary logic that swaps in a new half-period without a glitch.
// Ports:
//   clk      : system clock, all state on its rising edge
//   rst      : synchronous active-high reset
//   sync     : restart the channel at the start of its low phase
//   wr       : accepted config write for this channel
//   wr_half  : half-period carried by that write (0 disables)
//   div_clk  : registered divided square wave
//   tick     : one-cycle pulse on the first high cycle of each period
//   pend     : an accepted write is waiting for its boundary
// ---------------------------------------------------------------------------
module clkdiv_channel
   import clkdiv_pkg::*;
#(
   parameter int WIDTH        = 26,
   parameter int DEFAULT_HALF = DEFAULT_HALF_VALUE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sync,
   input  logic             wr,
   input  logic [WIDTH-1:0] wr_half,
   output logic             div_clk,
   output logic             tick,
   output logic             pend
);

   logic [WIDTH-1:0] half;
   logic [WIDTH-1:0] pend_half;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] half_nxt;
   logic [WIDTH-1:0] pend_half_nxt;
   logic [WIDTH-1:0] cnt_nxt;
   logic             div_nxt;
   logic             tick_nxt;
   logic             pend_nxt;
   logic             at_end;
   chan_op_t         op;

   // The last cycle of a half period; half-1 wraps in WIDTH bits on purpose,
   // but a disabled channel never reaches the counting branches anyway.
   assign at_end = (cnt == (half - WIDTH'(1)));

   // Pick the one action for this edge. Sync outranks everything else, a
   // disabled channel just idles, and a pending update is only taken on the
   // last high cycle so the running period always completes cleanly.
   always_comb begin
      op = OP_COUNT;
      if (sync) begin
         op = OP_SYNC;
      end else if (half == '0) begin
         op = OP_IDLE;
      end else if (at_end && div_clk && pend) begin
         op = OP_APPLY;
      end else if (at_end) begin
         op = OP_TOGGLE;
      end
   end

   // Next-state values for the chosen action. Sync and idle both park the
   // wave low and adopt any pending half-period at once. A write lands in the
   // pending register last; it can only be accepted while nothing is pending,
   // so it never races the clearing of pend above.
   always_comb begin
      half_nxt      = half;
      pend_half_nxt = pend_half;
      pend_nxt      = pend;
      cnt_nxt       = cnt;
      div_nxt       = div_clk;
      tick_nxt      = 1'b0;
      case (op)
         OP_SYNC, OP_IDLE: begin
            cnt_nxt = '0;
            div_nxt = 1'b0;
            if (pend) begin
               half_nxt = pend_half;
               pend_nxt = 1'b0;
            end
         end
         OP_APPLY: begin
            half_nxt = pend_half;
            pend_nxt = 1'b0;
            cnt_nxt  = '0;
            div_nxt  = 1'b0;
         end
         OP_TOGGLE: begin
            cnt_nxt  = '0;
            div_nxt  = ~div_clk;
            tick_nxt = ~div_clk;
         end
         default: begin
            cnt_nxt = cnt + WIDTH'(1);
         end
      endcase
      if (wr) begin
         pend_half_nxt = wr_half;
         pend_nxt      = 1'b1;
      end
   end

   // State register. Reset discards any pending write and reloads the
   // default half-period with the wave parked low.
   always_ff @(posedge clk) begin
      if (rst) begin
         half      <= WIDTH'(DEFAULT_HALF);
         pend_half <= '0;
         pend      <= 1'b0;
         cnt       <= '0;
         div_clk   <= 1'b0;
         tick      <= 1'b0;
      end else begin
         half      <= half_nxt;
         pend_half <= pend_half_nxt;
         pend      <= pend_nxt;
         cnt       <= cnt_nxt;
         div_clk   <= div_nxt;
         tick      <= tick_nxt;
      end
   end

endmodule

// File: rtl/clkdiv_multi.sv
// ---------------------------------------------------------------------------
// clkdiv_multi
// NCH independent clock dividers with a shared valid/ready config port.
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   cfg_valid  : config write request
//   cfg_ready  : write accepted when cfg_valid && cfg_ready
//   cfg_ch     : target channel; indices >= NCH are accepted and dropped
//   cfg_half   : new half-period, 0 disables the channel
//   sync       : phase-align every channel
//   div_clk    : divided square waves, one bit per channel
//   tick       : first-high-cycle pulse per channel
//   debug      : per-channel pending-update flags
// ---------------------------------------------------------------------------
module clkdiv_multi
   import clkdiv_pkg::*;
#(
   parameter  int NCH          = 4,
   parameter  int WIDTH        = 26,
   parameter  int DEFAULT_HALF = DEFAULT_HALF_VALUE,
   localparam int CH_W         = ch_width(NCH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [WIDTH-1:0] cfg_half,
   input  logic             sync,
   output logic [NCH-1:0]   div_clk,
   output logic [NCH-1:0]   tick,
   output logic [NCH-1:0]   debug
);

   localparam int NPAD = 1 << CH_W;

   logic [NCH-1:0]  pend;
   logic [NPAD-1:0] pend_ext;
   logic            accept;

   // Padding the pending flags out to every encodable index makes the
   // out-of-range channels read as "never pending", so they are always
   // ready and no separate range compare is needed.
   assign pend_ext  = NPAD'(pend);
   assign cfg_ready = ~pend_ext[cfg_ch];
   assign accept    = cfg_valid & cfg_ready;
   assign debug     = pend;

   // One channel per output bit; an out-of-range index matches none of the
   // write strobes, which is how such writes are dropped.
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic wr;

      assign wr = accept && (cfg_ch == CH_W'(i));

      clkdiv_channel #(
         .WIDTH        (WIDTH),
         .DEFAULT_HALF (DEFAULT_HALF)
      ) u_channel (
         .clk     (clk),
         .rst     (rst),
         .sync    (sync),
         .wr      (wr),
         .wr_half (cfg_half),
         .div_clk (div_clk[i]),
         .tick    (tick[i]),
         .pend    (pend[i])
      );
   end

endmodule
